// File: rtl/convertor_scheduler.sv
// Round-robin scheduler sharing one 6-bit to dual 7-segment convertor between two requesters.
// Convertor inputs are driven from flops. Each result is captured after a programmable settle time.
module convertor_scheduler #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ0,
  input  logic [5:0]  DATA0,
  output logic        ACK0,
  output logic [13:0] SEGA,
  input  logic        REQ1,
  input  logic [5:0]  DATA1,
  output logic        ACK1,
  output logic [13:0] SEGB,
  output logic [5:0]  CONV_T,
  input  logic [13:0] CONV_SEG,
  output logic        BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);

  state_t      r_state;
  logic        r_pend0, r_pend1;
  logic [5:0]  r_hold0, r_hold1;
  logic        r_last, r_gnt;
  logic [3:0]  r_cnt;
  logic [5:0]  r_conv_t;
  logic [13:0] r_sega, r_segb;
  logic        r_ack0, r_ack1;

  logic        w_grant_any, w_grant_sel, w_clr0, w_clr1;

  // On a tie the requester that was not served last wins.
  always_comb begin
    w_grant_any = (r_state == S_IDLE) && (r_pend0 || r_pend1);
    if (r_pend0 && r_pend1) w_grant_sel = ~r_last;
    else                    w_grant_sel = r_pend1;
    w_clr0 = w_grant_any && !w_grant_sel;
    w_clr1 = w_grant_any &&  w_grant_sel;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_pend0  <= 1'b0;
      r_pend1  <= 1'b0;
      r_hold0  <= '0;
      r_hold1  <= '0;
      r_last   <= 1'b1;
      r_gnt    <= 1'b0;
      r_cnt    <= '0;
      r_conv_t <= '0;
      r_sega   <= '0;
      r_segb   <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
    end else begin
      // A new request in the grant cycle keeps the flag set, so it is served again.
      r_pend0 <= REQ0 | (r_pend0 & ~w_clr0);
      r_pend1 <= REQ1 | (r_pend1 & ~w_clr1);
      if (REQ0) r_hold0 <= DATA0;
      if (REQ1) r_hold1 <= DATA1;
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_conv_t <= w_grant_sel ? r_hold1 : r_hold0;
            r_gnt    <= w_grant_sel;
            r_last   <= w_grant_sel;
            r_cnt    <= CNT_INIT;
            r_state  <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (r_gnt) r_segb <= CONV_SEG;
            else       r_sega <= CONV_SEG;
            r_ack0  <= ~r_gnt;
            r_ack1  <=  r_gnt;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ACK0   = r_ack0;
  assign ACK1   = r_ack1;
  assign SEGA   = r_sega;
  assign SEGB   = r_segb;
  assign CONV_T = r_conv_t;
  assign BUSY   = (r_state != S_IDLE);

endmodule

// File: tb/tb_convertor_scheduler.sv
// Scoreboard bench for convertor_scheduler: a transaction-level model predicts every ACK.
// A second instance with a longer settle time checks the capture point.
module tb_convertor_scheduler;

  localparam int S = 1;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REQ0 = 1'b0, REQ1 = 1'b0;
  logic [5:0]  DATA0 = '0, DATA1 = '0;
  logic        ACK0, ACK1, BUSY;
  logic [13:0] SEGA, SEGB, CONV_SEG;
  logic [5:0]  CONV_T;

  logic        REQ0_4 = 1'b0, REQ1_4 = 1'b0;
  logic [5:0]  DATA0_4 = '0, DATA1_4 = '0;
  logic        ACK0_4, ACK1_4, BUSY_4;
  logic [13:0] SEGA_4, SEGB_4, CONV_SEG_4;
  logic [5:0]  CONV_T_4;
  logic [13:0] noise4 = '0;

  int checks = 0, failures = 0;
  int cyc = 0;
  int ack_seen = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [13:0] conv(input logic [5:0] t);
    if (t == 6'd42) return 14'h1ABC;
    return 14'((int'(t) * 37 + 5) ^ (int'(t) << 7));
  endfunction

  assign CONV_SEG   = conv(CONV_T);
  assign CONV_SEG_4 = conv(CONV_T_4) ^ noise4;

  convertor_scheduler #(.SETTLE_CYC(S)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0(REQ0), .DATA0(DATA0), .ACK0(ACK0), .SEGA(SEGA),
    .REQ1(REQ1), .DATA1(DATA1), .ACK1(ACK1), .SEGB(SEGB),
    .CONV_T(CONV_T), .CONV_SEG(CONV_SEG), .BUSY(BUSY)
  );

  convertor_scheduler #(.SETTLE_CYC(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0(REQ0_4), .DATA0(DATA0_4), .ACK0(ACK0_4), .SEGA(SEGA_4),
    .REQ1(REQ1_4), .DATA1(DATA1_4), .ACK1(ACK1_4), .SEGB(SEGB_4),
    .CONV_T(CONV_T_4), .CONV_SEG(CONV_SEG_4), .BUSY(BUSY_4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: requests, one server, service occupies S+2 cycles.
  typedef struct {
    int          id;
    int          cyc;
    logic [5:0]  val;
    logic [13:0] seg;
  } exp_t;

  exp_t        sbq[$];
  bit          m_pend[2];
  logic [5:0]  m_hold[2];
  int          m_last, m_free, m_gcyc;
  logic [5:0]  ct_val, ct_prev;
  int          ct_at;
  logic [13:0] m_sega, m_segb;

  task automatic model_reset();
    sbq.delete();
    m_pend[0] = 0; m_pend[1] = 0;
    m_hold[0] = '0; m_hold[1] = '0;
    m_last = 1; m_free = 0; m_gcyc = -1;
    ct_val = '0; ct_prev = '0; ct_at = 0;
    m_sega = '0; m_segb = '0;
  endtask

  task automatic model_step(input int c, input bit r0, input logic [5:0] d0,
                            input bit r1, input logic [5:0] d1);
    int g;
    exp_t e;
    if (c >= m_free && (m_pend[0] || m_pend[1])) begin
      if (m_pend[0] && m_pend[1]) g = 1 - m_last;
      else                        g = m_pend[0] ? 0 : 1;
      e.id = g; e.cyc = c + S + 1; e.val = m_hold[g]; e.seg = conv(m_hold[g]);
      sbq.push_back(e);
      ct_prev = ct_val; ct_val = m_hold[g]; ct_at = c + 1;
      m_pend[g] = 0; m_last = g; m_gcyc = c; m_free = c + S + 2;
    end
    if (r0) begin m_pend[0] = 1; m_hold[0] = d0; end
    if (r1) begin m_pend[1] = 1; m_hold[1] = d1; end
  endtask

  task automatic drive_cycle(input bit r0, input logic [5:0] d0,
                             input bit r1, input logic [5:0] d1);
    @(posedge CLK);
    #1;
    chk("busy", 32'(BUSY), 32'((cyc > m_gcyc) && (cyc < m_free)));
    REQ0 = r0; DATA0 = d0; REQ1 = r1; DATA1 = d1;
    model_step(cyc, r0, d0, r1, d1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, '0, 0, '0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_conv_t"}, 32'(CONV_T), 32'd0);
    chk({tag, "_sega"},   32'(SEGA),   32'd0);
    chk({tag, "_segb"},   32'(SEGB),   32'd0);
    chk({tag, "_acks"},   32'({ACK0, ACK1}), 32'd0);
    chk({tag, "_busy"},   32'(BUSY),   32'd0);
  endtask

  task automatic do_reset(input int n);
    RST_N = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      REQ0 = 1'($urandom); DATA0 = 6'($urandom);
      REQ1 = 1'($urandom); DATA1 = 6'($urandom);
    end
    @(posedge CLK);
    #1;
    REQ0 = 1'b0; REQ1 = 1'b0;
    #1;
    check_zero("reset");
    RST_N = 1'b1;
  endtask

  // Monitor: every ACK pops one expected service; result registers are tracked between ACKs.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (ACK0 && ACK1) chk("ack_exclusive", 32'({ACK0, ACK1}), 32'd0);
      if (ACK0 || ACK1) begin
        exp_t e;
        ack_seen++;
        if (sbq.size() == 0) begin
          chk("unexpected_ack", 32'({ACK0, ACK1}), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("ack_id",     32'(ACK1),   32'(e.id));
          chk("ack_cycle",  32'(cyc),    32'(e.cyc));
          chk("ack_conv_t", 32'(CONV_T), 32'(e.val));
          if (e.id == 0) m_sega = e.seg;
          else           m_segb = e.seg;
        end
      end
      chk("sega",   32'(SEGA),   32'(m_sega));
      chk("segb",   32'(SEGB),   32'(m_segb));
      chk("conv_t", 32'(CONV_T), 32'((cyc >= ct_at) ? ct_val : ct_prev));
    end
  end

  initial begin
    int acks_before;
    model_reset();
    do_reset(4);

    // Single request, latency and capture
    drive_cycle(1, 6'd42, 0, '0);
    idle(6);

    // Tie after reset, then tie again
    do_reset(2);
    drive_cycle(1, 6'd5, 1, 6'd63);
    idle(8);
    drive_cycle(1, 6'd5, 1, 6'd63);
    idle(8);

    // Overwrite while requester 0 holds the convertor
    drive_cycle(1, 6'd1, 0, '0);
    drive_cycle(0, '0, 1, 6'd10);
    drive_cycle(0, '0, 1, 6'd11);
    idle(8);

    // Re-request in the grant cycle
    drive_cycle(1, 6'd20, 0, '0);
    drive_cycle(1, 6'd33, 0, '0);
    idle(10);

    // Random traffic
    for (int i = 0; i < 400; i++)
      drive_cycle($urandom_range(3) == 0, 6'($urandom), $urandom_range(3) == 0, 6'($urandom));
    idle(10);

    // Reset while in DRIVE
    drive_cycle(1, 6'd9, 0, '0);
    drive_cycle(0, '0, 0, '0);
    drive_cycle(0, '0, 0, '0);
    chk("pre_reset_busy", 32'(BUSY), 32'd1);
    #1;
    RST_N = 1'b0;
    model_reset();
    #1;
    check_zero("mid_reset");
    acks_before = ack_seen;
    repeat (3) @(posedge CLK);
    #2;
    RST_N = 1'b1;
    idle(6);
    chk("no_ack_after_reset", 32'(ack_seen), 32'(acks_before));

    for (int i = 0; i < 40 && sbq.size() > 0; i++) idle(1);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    // Settle time of 4: capture point and ACK distance
    @(posedge CLK);
    #1;
    REQ1_4 = 1'b1; DATA1_4 = 6'd7;
    for (int k = 1; k <= 7; k++) begin
      @(posedge CLK);
      #1;
      REQ1_4 = 1'b0;
      chk("s4_busy", 32'(BUSY_4), 32'(k >= 2 && k <= 6));
      chk("s4_ack1", 32'(ACK1_4), 32'(k == 6));
      chk("s4_ack0", 32'(ACK0_4), 32'd0);
      if (k >= 2) chk("s4_conv_t", 32'(CONV_T_4), 32'd7);
      chk("s4_segb", 32'(SEGB_4), 32'((k >= 6) ? conv(6'd7) : 14'd0));
      chk("s4_sega", 32'(SEGA_4), 32'd0);
      noise4 = (k >= 2 && k <= 4) ? 14'($urandom_range(16383, 1)) : 14'd0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/convertor_scheduler.md
Name: convertor_scheduler

Overview:
- Time-shares one 6-bit-to-dual-7-segment convertor between two requesters.
- Each requester posts a 6-bit value with a one-cycle request pulse. The scheduler arbitrates round-robin and drives the value onto the convertor inputs.
- It waits a programmable settle time, captures the 14 segment outputs into that requester's result register, and returns a one-cycle ACK.
- Sits between the control logic and the combinational convertor; all convertor inputs come from flops, so the path is scan-friendly.

Parameters:
- SETTLE_CYC, 1, cycles CONV_T is held before CONV_SEG is sampled; legal range 1..15 (4-bit counter).

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- REQ0  in  1  requester 0 request pulse, one cycle
- DATA0  in  6  requester 0 value, sampled when REQ0=1
- ACK0  out  1  requester 0 done pulse, one cycle
- SEGA  out  14  requester 0 result {G1,F1,E1,D1,C1,B1,A1,G0,F0,E0,D0,C0,B0,A0}
- REQ1  in  1  requester 1 request pulse
- DATA1  in  6  requester 1 value
- ACK1  out  1  requester 1 done pulse
- SEGB  out  14  requester 1 result, same packing as SEGA
- CONV_T  out  6  convertor input {T5..T0}, registered
- CONV_SEG  in  14  convertor output, same packing as SEGA
- BUSY  out  1  high whenever state is not IDLE

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE; PEND0=PEND1=0; HOLD0=HOLD1=0.
  - CONV_T=0, SEGA=SEGB=0, ACK0=ACK1=0, BUSY=0.
  - Priority pointer LAST=1, so requester 0 wins the first tie.
  - Deassertion is used synchronously through the normal flop path. No extra synchroniser is included here.
- Request capture, every cycle regardless of state:
  - REQn=1 sets PENDn and loads HOLDn<=DATAn.
  - REQn while PENDn=1 and not yet granted: HOLDn is overwritten (latest value wins) and only one service is performed.
  - REQn in the same cycle its grant clears PENDn: the set wins, so PENDn stays 1 with the new data and the requester is serviced again later.
- State machine, states IDLE, DRIVE, DONE:
  - IDLE:
    - If only PEND0 or only PEND1 is set, grant that requester.
    - If both are set, grant the requester != LAST.
    - On grant: CONV_T<=HOLDg, PENDg<=0 (unless re-set that cycle), GNT<=g, LAST<=g, CNT<=SETTLE_CYC-1, go to DRIVE.
    - If neither is pending, stay in IDLE.
  - DRIVE:
    - CONV_T stays stable.
    - If CNT!=0, CNT<=CNT-1.
    - If CNT==0: load SEGA (GNT=0) or SEGB (GNT=1) with CONV_SEG, assert ACKg for the next cycle, go to DONE.
  - DONE: ACKg=1 for this single cycle, then go to IDLE unconditionally.
- Latency with SETTLE_CYC=1:
  - REQ at cycle 0 → PEND at cycle 1 → DRIVE at cycle 2 → DONE/ACK and SEG updated at cycle 3.
  - Generally ACK follows REQ by SETTLE_CYC+2 cycles when uncontended.
  - Service period per request is SETTLE_CYC+2 cycles.
- Output holding rules:
  - CONV_T holds its last driven value in IDLE and DONE. It never changes except on a grant.
  - SEGA and SEGB change only in the DRIVE→DONE transition for the granted requester; otherwise they hold.
- ACK rules: ACK0 and ACK1 are never high together. At most one ACK pulse per service.
- Reset mid-service: all state is discarded immediately, pending requests are lost, and no ACK is issued.
- The scheduler performs no arithmetic beyond the down-counter. CNT is 4 bits and never wraps below 0.

Test Plan:
- Reset: hold RST_N=0 with random inputs, then release → CONV_T=0, SEGA=SEGB=0, ACK0/1=0, BUSY=0. Assert RST_N low mid-DRIVE → everything returns to 0 within the same cycle and no ACK follows.
- Single request, SETTLE_CYC=1: REQ0 pulse with DATA0=42; bench convertor model returns 14'h1ABC when CONV_T==42 → CONV_T=42 from cycle 2, ACK0 at cycle 3, SEGA=14'h1ABC, SEGB unchanged, BUSY high at cycles 2-3.
- Tie arbitration: REQ0 (DATA0=5) and REQ1 (DATA1=63) in the same cycle after reset → requester 0 served first, then requester 1. Repeat the tie → requester 0 first again, since LAST=1 after the previous round.
- Overwrite: REQ1 with DATA1=10, then REQ1 with DATA1=11 before the grant → one ACK1 only; CONV_T=11 during DRIVE.
- Re-request at grant: REQ0 pulse (DATA0=33) in the exact cycle requester 0 is granted with its old value 20 → first service uses 20, then a second service uses 33, giving two ACK0 pulses.
- SETTLE_CYC=4: REQ1 with DATA1=7 → CONV_T is stable for exactly 4 DRIVE cycles, ACK1 comes 6 cycles after REQ1, and SEGB captures CONV_SEG from the last DRIVE cycle. Bench changes CONV_SEG in the earlier DRIVE cycles to prove the sampling point.
